// File: rtl/dice_pkg.sv
// Shared types and 7-segment constants for the dice game front end.
package dice_pkg;

  typedef enum logic {IDLE, TUMBLE} state_t;

  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [3:0] FACE_RESET = 4'd1;

  // Bit order {g,f,e,d,c,b,a}; anything that is not a die face shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] face_val);
    case (face_val)
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, one-cycle press event.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic          btn_db;
  logic          btn_db_q;
  logic [CW-1:0] db_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      btn_db    <= 1'b0;
      btn_db_q  <= 1'b0;
      press_evt <= 1'b0;
      db_cnt    <= '0;
    end else begin
      sync_1    <= btn_raw;
      sync_2    <= sync_1;
      btn_db_q  <= btn_db;
      press_evt <= btn_db & ~btn_db_q;
      // Level is accepted only after an unbroken run of differing samples.
      if (sync_2 != btn_db) begin
        if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          btn_db <= sync_2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dice_roll_sequencer.sv
// Dice roll front end: debounced press launches a slowing burst of roll requests.
//   IDLE   | waiting for a press; done pulses here for one cycle after a roll
//   TUMBLE | issuing one roll_pulse per step, steps growing by STEP_INC
module dice_roll_sequencer
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STEP_BASE       = 100000,
  parameter int STEP_INC        = 25000,
  parameter int NUM_STEPS       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic [3:0] dice_value,
  output logic       roll_pulse,
  output logic [3:0] face,
  output logic [6:0] seg,
  output logic       busy,
  output logic       done
);

  localparam int TW = $clog2(STEP_BASE + (NUM_STEPS - 1) * STEP_INC + 1);
  localparam int SW = $clog2(NUM_STEPS + 1);

  state_t        state;
  logic          press_evt;
  logic          load;
  logic [TW-1:0] timer;
  logic [TW-1:0] interval;
  logic [SW-1:0] step;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_debounce (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .press_evt (press_evt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      step       <= '0;
      interval   <= '0;
      timer      <= '0;
      roll_pulse <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load       <= 1'b0;
      face       <= FACE_RESET;
    end else begin
      // Dice stage answers one cycle after the request, so capture is delayed by load.
      load       <= roll_pulse;
      if (load) face <= dice_value;
      done       <= 1'b0;
      roll_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (press_evt) begin
            state      <= TUMBLE;
            step       <= '0;
            interval   <= TW'(STEP_BASE);
            timer      <= '0;
            roll_pulse <= 1'b1;
            busy       <= 1'b1;
          end
        end
        TUMBLE: begin
          if (timer == interval - TW'(1)) begin
            if (step < SW'(NUM_STEPS - 1)) begin
              step       <= step + SW'(1);
              interval   <= interval + TW'(STEP_INC);
              timer      <= '0;
              roll_pulse <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign seg = seg_decode(face);

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// Self-checking bench for dice_roll_sequencer with a timing-schedule reference model.
module tb_dice_roll_sequencer;

  localparam int DB    = 4;
  localparam int SB    = 4;
  localparam int SI    = 2;
  localparam int NS    = 3;
  localparam int TOTAL = NS * SB + SI * NS * (NS - 1) / 2;
  localparam int LEAD  = DB + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_raw = 1'b0;
  logic [3:0] dice_value = 4'd0;
  logic       roll_pulse;
  logic [3:0] face;
  logic [6:0] seg;
  logic       busy;
  logic       done;

  dice_roll_sequencer #(
    .DEBOUNCE_CYCLES (DB),
    .STEP_BASE       (SB),
    .STEP_INC        (SI),
    .NUM_STEPS       (NS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .dice_value (dice_value),
    .roll_pulse (roll_pulse),
    .face       (face),
    .seg        (seg),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         total = 0;
  int         bad = 0;
  int         pulse_q[$];
  int         done_q[$];
  int         busy_cnt = 0;
  int         force_q[$];
  int         last_gen = 1;
  logic       pend;
  logic [6:0] seg_tab[16];

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int step_start(input int i);
    return i * SB + SI * i * (i - 1) / 2;
  endfunction

  // Observer: logs roll requests and done pulses by cycle number.
  initial forever begin
    @(negedge clk);
    if (roll_pulse) pulse_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
    if (busy) busy_cnt++;
  end

  // Dice stage model: new value valid the cycle after each roll request.
  initial forever begin
    @(negedge clk);
    pend = roll_pulse;
    @(posedge clk);
    #1;
    if (pend) begin
      if (force_q.size() > 0) last_gen = force_q.pop_front();
      else last_gen = int'($urandom_range(0, 15));
      dice_value = last_gen[3:0];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic clear_log();
    pulse_q.delete();
    done_q.delete();
    busy_cnt = 0;
  endtask

  task automatic press(input int hold, output int p);
    btn_raw = 1'b1;
    p = cyc + 1;
    tick(hold);
    btn_raw = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check_val("done_wait", done_q.size(), n);
  endtask

  task automatic check_roll(input string tag, input int p);
    check_val({tag, "_npulse"}, pulse_q.size(), NS);
    for (int i = 0; i < NS; i++) begin
      if (i < pulse_q.size())
        check_val($sformatf("%s_pulse%0d", tag, i), pulse_q[i], p + LEAD + step_start(i));
      else
        check_val($sformatf("%s_pulse%0d", tag, i), -1, p + LEAD + step_start(i));
    end
    check_val({tag, "_ndone"}, done_q.size(), 1);
    if (done_q.size() > 0) check_val({tag, "_done_cyc"}, done_q[0], p + LEAD + TOTAL);
    check_val({tag, "_busy_len"}, busy_cnt, TOTAL);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int p2;
    int sweep_val[8];
    int sweep_seg[8];

    for (int i = 0; i < 16; i++) seg_tab[i] = 7'h40;
    seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D;
    sweep_val = '{1, 2, 3, 4, 5, 6, 0, 9};
    sweep_seg = '{'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h40, 'h40};

    // Reset state
    tick(3);
    check_val("rst_roll_pulse", roll_pulse, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_face", face, 1);
    check_val("rst_seg", seg, 'h06);
    reset = 1'b0;
    tick(3);

    // Bounce
    clear_log();
    for (int i = 0; i < 10; i++) begin
      btn_raw = ~btn_raw;
      tick(2);
    end
    btn_raw = 1'b0;
    tick(20);
    check_val("bounce_npulse", pulse_q.size(), 0);
    check_val("bounce_ndone", done_q.size(), 0);
    check_val("bounce_face", face, 1);
    check_val("bounce_seg", seg, 'h06);

    // Clean presses with random hold, random dice and random gaps
    for (int r = 0; r < 4; r++) begin
      clear_log();
      press(int'($urandom_range(6, 40)), p);
      wait_done(1, 80);
      tick(2);
      check_roll($sformatf("clean%0d", r), p);
      check_val($sformatf("clean%0d_face", r), face, last_gen);
      check_val($sformatf("clean%0d_seg", r), seg, seg_tab[last_gen]);
      tick(int'($urandom_range(12, 25)));
    end

    // Second press during tumble is ignored
    clear_log();
    press(8, p);
    tick_to(p + 14);
    btn_raw = 1'b1;
    tick(10);
    btn_raw = 1'b0;
    tick_to(p + 70);
    check_roll("ignore", p);
    check_val("ignore_face", face, last_gen);

    // Reset mid-roll
    clear_log();
    press(6, p);
    tick_to(p + LEAD + 5);
    reset = 1'b1;
    #1;
    check_val("midrst_busy_async", busy, 0);
    check_val("midrst_face_async", face, 1);
    tick(1);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_face", face, 1);
    check_val("midrst_seg", seg, 'h06);
    check_val("midrst_roll_pulse", roll_pulse, 0);
    tick(1);
    reset = 1'b0;
    tick(40);
    check_val("midrst_npulse", pulse_q.size(), 2);
    check_val("midrst_ndone", done_q.size(), 0);
    check_val("midrst_busy_after", busy, 0);

    // Decode sweep
    for (int i = 0; i < 8; i++) begin
      clear_log();
      force_q.push_back(int'($urandom_range(0, 15)));
      force_q.push_back(int'($urandom_range(0, 15)));
      force_q.push_back(sweep_val[i]);
      press(6, p);
      wait_done(1, 60);
      tick(2);
      check_val($sformatf("sweep%0d_face", i), face, sweep_val[i]);
      check_val($sformatf("sweep%0d_seg", i), seg, sweep_seg[i]);
      tick(12);
    end

    // Long hold gives one roll; release and re-press gives another
    clear_log();
    press(200, p);
    check_roll("hold", p);
    tick(15);
    clear_log();
    press(6, p2);
    wait_done(1, 60);
    tick(2);
    check_roll("repress", p2);
    check_val("repress_face", face, last_gen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
